// File: rtl/fir_coeff_ctrl.sv
// Coefficient bank controller for a FIR: double-buffered taps, flush on swap,
// and output discard. Optional counters are enabled by FIR_CTRL_STATS_EN.
module fir_coeff_ctrl #(
  parameter int NUM_COEFFS = 15,
  parameter int DATA_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wr_en,
  input  logic [3:0]              cfg_wr_addr,
  input  logic [7:0]              cfg_wr_data,
  input  logic                    cfg_commit,
  output logic                    cfg_busy,
  output logic                    cfg_err,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_W-1:0]       fir_data,
  output logic                    fir_valid,
  output logic [NUM_COEFFS*8-1:0] fir_coeffs,
  input  logic [DATA_W-1:0]       fir_out_data,
  input  logic                    fir_out_valid,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_valid,
  output logic [1:0]              dbg_state
`ifdef FIR_CTRL_STATS_EN
  ,
  output logic [15:0]             stat_samples,
  output logic [15:0]             stat_commits
`endif
);

  // Handshake: a sample transfers on a rising edge where s_valid && s_ready;
  // fir_valid/fir_out_valid/m_valid are plain qualifiers with no backpressure.

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SWAP  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int              CNT_W    = $clog2(NUM_COEFFS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_COEFFS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_COEFFS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       ADDR_LIM = 5'(NUM_COEFFS);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic             pending_q, pending_d;
  logic             cfg_err_q, cfg_err_d;
  logic [7:0]       shadow_q [NUM_COEFFS];
  logic [7:0]       shadow_d [NUM_COEFFS];
  logic [7:0]       active_q [NUM_COEFFS];
  logic [7:0]       active_d [NUM_COEFFS];
  logic             wr_in_range;

  assign wr_in_range = ({1'b0, cfg_wr_addr} < ADDR_LIM);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pending_d   = pending_q;
    discard_d   = discard_q;
    cfg_err_d   = cfg_err_q | (cfg_wr_en & ~wr_in_range);
    shadow_d    = shadow_q;
    active_d    = active_q;

    for (int i = 0; i < NUM_COEFFS; i++) begin
      if (cfg_wr_en && wr_in_range && (cfg_wr_addr == 4'(i))) begin
        shadow_d[i] = cfg_wr_data;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (cfg_commit) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        active_d    = shadow_q;
        flush_cnt_d = CNT_LAST;
        state_d     = ST_FLUSH;
        if (cfg_commit) pending_d = 1'b1;
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          // A commit arriving on the last flush cycle chains a swap just like a latched one.
          if (pending_q || cfg_commit) begin
            state_d   = ST_SWAP;
            pending_d = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_ONE;
          if (cfg_commit) pending_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (state_q == ST_SWAP) begin
      discard_d = CNT_LOAD;
    end else if (fir_out_valid && (discard_q != '0)) begin
      discard_d = discard_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      discard_q   <= '0;
      pending_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      discard_q   <= discard_d;
      pending_q   <= pending_d;
      cfg_err_q   <= cfg_err_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  always_comb begin
    s_ready   = (state_q == ST_RUN);
    fir_data  = (state_q == ST_RUN) ? s_data : '0;
    fir_valid = (state_q == ST_RUN) ? s_valid : (state_q == ST_FLUSH);
    cfg_busy  = (state_q != ST_RUN) || pending_q;
    cfg_err   = cfg_err_q;
    m_data    = fir_out_data;
    m_valid   = fir_out_valid && (discard_q == '0);
    dbg_state = state_q;
  end

  for (genvar g = 0; g < NUM_COEFFS; g++) begin : g_coeffs
    assign fir_coeffs[g*8 +: 8] = active_q[g];
  end

`ifdef FIR_CTRL_STATS_EN
  logic [15:0] stat_samples_q, stat_samples_d;
  logic [15:0] stat_commits_q, stat_commits_d;

  always_comb begin
    stat_samples_d = stat_samples_q;
    stat_commits_d = stat_commits_q;
    if (s_valid && s_ready && (stat_samples_q != 16'hFFFF)) begin
      stat_samples_d = stat_samples_q + 16'd1;
    end
    if ((state_q == ST_SWAP) && (stat_commits_q != 16'hFFFF)) begin
      stat_commits_d = stat_commits_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_samples_q <= '0;
      stat_commits_q <= '0;
    end else begin
      stat_samples_q <= stat_samples_d;
      stat_commits_q <= stat_commits_d;
    end
  end

  assign stat_samples = stat_samples_q;
  assign stat_commits = stat_commits_q;
`endif

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl; a one-cycle loopback stands in for the FIR
// (result = sample + 7). Stats checks build only with FIR_CTRL_STATS_EN.
module tb_fir_coeff_ctrl;
  localparam int N  = 15;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          cfg_wr_en;
  logic [3:0]    cfg_wr_addr;
  logic [7:0]    cfg_wr_data;
  logic          cfg_commit;
  logic          cfg_busy;
  logic          cfg_err;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] fir_data;
  logic          fir_valid;
  logic [N*8-1:0] fir_coeffs;
  logic [DW-1:0] fir_out_data;
  logic          fir_out_valid;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [1:0]    dbg_state;
`ifdef FIR_CTRL_STATS_EN
  logic [15:0]   stat_samples;
  logic [15:0]   stat_commits;
`endif

  int   checks = 0;
  int   errors = 0;
  logic fb_en  = 1'b0;

  logic [N*8-1:0] ones_c;
  logic [N*8-1:0] exp_c;

  fir_coeff_ctrl #(.NUM_COEFFS(N), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_addr   (cfg_wr_addr),
    .cfg_wr_data   (cfg_wr_data),
    .cfg_commit    (cfg_commit),
    .cfg_busy      (cfg_busy),
    .cfg_err       (cfg_err),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .fir_data      (fir_data),
    .fir_valid     (fir_valid),
    .fir_coeffs    (fir_coeffs),
    .fir_out_data  (fir_out_data),
    .fir_out_valid (fir_out_valid),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .dbg_state     (dbg_state)
`ifdef FIR_CTRL_STATS_EN
    ,
    .stat_samples  (stat_samples),
    .stat_commits  (stat_commits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: settle, sample what goes to the FIR, edge, then loop it back.
  task automatic cycle();
    logic          fv;
    logic [DW-1:0] fd;
    #1;
    fv = fir_valid;
    fd = fir_data;
    @(posedge clk);
    #1;
    if (fb_en) begin
      fir_out_valid = fv;
      fir_out_data  = fd + 32'd7;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; cfg_commit = 1'b0;
    s_data = '0; s_valid = 1'b0; fir_out_data = '0; fir_out_valid = 1'b0; fb_en = 1'b0;
    cycle(); cycle();
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", cfg_busy); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", cfg_err); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", s_ready); end
    checks++; if (fir_coeffs !== '0) begin errors++; $display("FAIL reset_coeffs got %0h exp 0", fir_coeffs); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    rst = 1'b0;
    cycle();
    s_valid = 1'b1; s_data = 32'h55; fir_out_valid = 1'b1; fir_out_data = 32'h1234;
    #1;
    checks++; if ({fir_valid, fir_data} !== {1'b1, 32'h55}) begin errors++; $display("FAIL run_pass got %0b/%0h exp 1/55", fir_valid, fir_data); end
    checks++; if ({m_valid, m_data} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL run_out got %0b/%0h exp 1/1234", m_valid, m_data); end
    s_valid = 1'b0; fir_out_valid = 1'b0;
  endtask

  task automatic test_commit_flush();
    int n;
    logic exp_mv;
    fb_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      cfg_wr_en = 1'b1; cfg_wr_addr = 4'(i); cfg_wr_data = 8'h01;
      cycle();
    end
    cfg_wr_en = 1'b0;
    checks++; if (fir_coeffs !== '0) begin errors++; $display("FAIL shadow_only got %0h exp 0", fir_coeffs); end
    s_valid = 1'b1; s_data = 32'd100; cfg_commit = 1'b1;
    #1;
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL busy_before_edge got %0b exp 0", cfg_busy); end
    cycle();
    cfg_commit = 1'b0;
    checks++; if ({cfg_busy, s_ready, fir_valid} !== 3'b100) begin errors++; $display("FAIL swap_outputs busy/ready/valid got %03b exp 100", {cfg_busy, s_ready, fir_valid}); end
    checks++; if (fir_coeffs !== '0) begin errors++; $display("FAIL swap_coeffs got %0h exp 0", fir_coeffs); end
    cycle();
    checks++; if (fir_coeffs !== ones_c) begin errors++; $display("FAIL coeffs_after_swap got %0h exp %0h", fir_coeffs, ones_c); end
    n = 0;
    for (int c = 0; c < 35; c++) begin
      if (fir_out_valid) n++;
      exp_mv = fir_out_valid && (n > N);
      checks++; if (m_valid !== exp_mv) begin errors++; $display("FAIL discard c=%0d got %0b exp %0b", c, m_valid, exp_mv); end
      if (c < N) begin
        checks++;
        if ({fir_valid, fir_data == '0, s_ready, cfg_busy} !== 4'b1101) begin
          errors++; $display("FAIL flush c=%0d valid/zero/ready/busy got %04b exp 1101", c, {fir_valid, fir_data == '0, s_ready, cfg_busy});
        end
      end else begin
        checks++;
        if ({s_ready, fir_valid, cfg_busy, fir_data} !== {3'b110, 32'd100}) begin
          errors++; $display("FAIL run c=%0d ready/valid/busy got %03b data %0d exp 110 100", c, {s_ready, fir_valid, cfg_busy}, fir_data);
        end
      end
      if (exp_mv) begin
        checks++; if (m_data !== 32'd107) begin errors++; $display("FAIL m_data c=%0d got %0d exp 107", c, m_data); end
      end
      cycle();
    end
  endtask

  task automatic test_recommit();
    int nflush;
    int nswap;
    logic sent;
    exp_c = ones_c;
    exp_c[7:0] = 8'hFE;
    nflush = 0; nswap = 0; sent = 1'b0;
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    for (int c = 0; c < 80 && !s_ready; c++) begin
      checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL recommit_busy c=%0d got %0b exp 1", c, cfg_busy); end
      if (fir_valid) nflush++; else nswap++;
      if (nflush >= 1) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL recommit_suppress c=%0d got %0b exp 0", c, m_valid); end
      end
      if (nflush == 4 && fir_valid) begin
        checks++; if (fir_coeffs !== ones_c) begin errors++; $display("FAIL active_isolated got %0h exp %0h", fir_coeffs, ones_c); end
      end
      if (nflush == 3 && fir_valid && !sent) begin
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0; cfg_wr_data = 8'hFE; cfg_commit = 1'b1; sent = 1'b1;
      end else begin
        cfg_wr_en = 1'b0; cfg_commit = 1'b0;
      end
      cycle();
    end
    checks++; if (nflush !== 30) begin errors++; $display("FAIL recommit_flush_pulses got %0d exp 30", nflush); end
    checks++; if (nswap !== 2) begin errors++; $display("FAIL recommit_swaps got %0d exp 2", nswap); end
    checks++; if (fir_coeffs !== exp_c) begin errors++; $display("FAIL recommit_coeffs got %0h exp %0h", fir_coeffs, exp_c); end
    checks++; if ({s_ready, cfg_busy} !== 2'b10) begin errors++; $display("FAIL recommit_run ready/busy got %02b exp 10", {s_ready, cfg_busy}); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reswap_reload_last got %0b exp 0", m_valid); end
    cycle();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL reswap_first_real got %0b exp 1", m_valid); end
  endtask

  task automatic test_cfg_err_and_same_cycle();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_initial got %0b exp 0", cfg_err); end
    cfg_wr_en = 1'b1; cfg_wr_addr = 4'd15; cfg_wr_data = 8'h07;
    cycle();
    cfg_wr_en = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_set got %0b exp 1", cfg_err); end
    cycle(); cycle(); cycle();
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", cfg_err); end
    // Write and commit together: tap 5 must land in the newly active bank.
    cfg_wr_en = 1'b1; cfg_wr_addr = 4'd5; cfg_wr_data = 8'h33; cfg_commit = 1'b1;
    cycle();
    cfg_wr_en = 1'b0; cfg_commit = 1'b0;
    for (int c = 0; c < 40 && !s_ready; c++) cycle();
    exp_c[47:40] = 8'h33;
    checks++; if (fir_coeffs !== exp_c) begin errors++; $display("FAIL same_cycle_commit got %0h exp %0h", fir_coeffs, exp_c); end
    checks++; if ({s_ready, cfg_err} !== 2'b11) begin errors++; $display("FAIL after_commit ready/err got %02b exp 11", {s_ready, cfg_err}); end
  endtask

  task automatic test_reset_mid_flush();
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    checks++; if ({fir_valid, dbg_state} !== {1'b1, 2'd2}) begin errors++; $display("FAIL pre_reset_flush got %0b/%0d exp 1/2", fir_valid, dbg_state); end
    rst = 1'b1; s_valid = 1'b0;
    #1;
    checks++; if ({fir_valid, cfg_busy, cfg_err, s_ready} !== 4'b0001) begin errors++; $display("FAIL async_reset valid/busy/err/ready got %04b exp 0001", {fir_valid, cfg_busy, cfg_err, s_ready}); end
    checks++; if (fir_coeffs !== '0) begin errors++; $display("FAIL reset_clears_bank got %0h exp 0", fir_coeffs); end
    cycle();
    checks++; if (fir_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got %0b exp 0", fir_valid); end
    rst = 1'b0;
    cycle();
    checks++; if ({s_ready, cfg_busy, dbg_state} !== {2'b10, 2'd0}) begin errors++; $display("FAIL post_reset ready/busy/state got %0b%0b/%0d exp 10/0", s_ready, cfg_busy, dbg_state); end
    s_valid = 1'b1; s_data = 32'd9;
    #1;
    checks++; if ({fir_valid, fir_data} !== {1'b1, 32'd9}) begin errors++; $display("FAIL post_reset_pass got %0b/%0d exp 1/9", fir_valid, fir_data); end
    s_valid = 1'b0;
  endtask

`ifdef FIR_CTRL_STATS_EN
  task automatic test_stats();
    rst = 1'b1; s_valid = 1'b0;
    cycle();
    checks++; if ({stat_samples, stat_commits} !== 32'd0) begin errors++; $display("FAIL stats_reset got %0h/%0h exp 0/0", stat_samples, stat_commits); end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cfg_commit = 1'b1;
      cycle();
      cfg_commit = 1'b0;
      cycle();
      for (int c = 0; c < 40 && !s_ready; c++) cycle();
    end
    s_valid = 1'b1;
    for (int i = 0; i < 70000; i++) cycle();
    s_valid = 1'b0;
    cycle();
    checks++; if (stat_samples !== 16'hFFFF) begin errors++; $display("FAIL stat_samples got %0h exp ffff", stat_samples); end
    checks++; if (stat_commits !== 16'd2) begin errors++; $display("FAIL stat_commits got %0d exp 2", stat_commits); end
  endtask
`endif

  initial begin
    ones_c = '0;
    for (int i = 0; i < N; i++) ones_c[i*8 +: 8] = 8'h01;
    exp_c = ones_c;
    test_reset();
    test_commit_flush();
    test_recommit();
    test_cfg_err_and_same_cycle();
    test_reset_mid_flush();
`ifdef FIR_CTRL_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_ctrl.md
FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 Parameter NUM_COEFFS, default 15: tap count of the controlled FIR.
REQ-002 Parameter DATA_W, default 32: sample width.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cfg_wr_en  input  1  write strobe for the shadow coefficient bank.
REQ-006 cfg_wr_addr  input  4  tap index to write.
REQ-007 cfg_wr_data  input  8  signed coefficient value.
REQ-008 cfg_commit  input  1  single-cycle pulse requesting a shadow-to-active swap.
REQ-009 cfg_busy  output  1  high while a swap/flush is pending or in progress.
REQ-010 cfg_err  output  1  sticky flag: write attempted with cfg_wr_addr >= NUM_COEFFS.
REQ-011 s_data  input  DATA_W  signed input sample.
REQ-012 s_valid  input  1  input sample valid.
REQ-013 s_ready  output  1  controller accepts the sample this cycle.
REQ-014 fir_data  output  DATA_W  sample to the FIR.
REQ-015 fir_valid  output  1  sample valid to the FIR.
REQ-016 fir_coeffs  output  NUM_COEFFS x 8  active coefficient bank, packed signed.
REQ-017 fir_out_data  input  DATA_W  FIR result.
REQ-018 fir_out_valid  input  1  FIR result valid.
REQ-019 m_data  output  DATA_W  filtered result, equal to fir_out_data (combinational).
REQ-020 m_valid  output  1  result valid after flush-output suppression.

Function
REQ-021 The shadow bank SHALL be written on any cycle with cfg_wr_en=1 and cfg_wr_addr < NUM_COEFFS, independent of state.
REQ-022 An out-of-range write SHALL be ignored and SHALL set cfg_err, which stays set until reset.
REQ-023 The FSM SHALL have states RUN, SWAP, FLUSH.
REQ-024 In RUN: s_ready=1; fir_data=s_data; fir_valid=s_valid; no added latency.
REQ-025 A cfg_commit in RUN SHALL move to SWAP on the next edge; cfg_busy SHALL rise on that edge.
REQ-026 A cfg_wr_en and cfg_commit in the same cycle SHALL include that write in the committed bank.
REQ-027 SWAP SHALL last exactly one cycle: active bank <= shadow bank; s_ready=0, fir_valid=0; next state FLUSH.
REQ-028 FLUSH SHALL drive exactly NUM_COEFFS consecutive cycles of fir_valid=1, fir_data=0, s_ready=0, then return to RUN.
REQ-029 A cfg_commit received in SWAP or FLUSH SHALL be latched as pending; on FLUSH completion, FSM SHALL go to SWAP instead of RUN, and the pending flag clears.
REQ-030 cfg_busy SHALL be high in SWAP, FLUSH, or while a commit is pending; low otherwise.
REQ-031 A discard counter SHALL load NUM_COEFFS in SWAP and decrement on each fir_out_valid pulse while nonzero.
REQ-032 m_valid SHALL equal fir_out_valid AND (discard counter == 0); the pulse that decrements the counter is suppressed.
REQ-033 A re-SWAP SHALL reload the discard counter to NUM_COEFFS regardless of its current value.
REQ-034 Writes to the shadow bank during SWAP/FLUSH SHALL NOT affect the active bank until the next SWAP.

Reset
REQ-035 rst SHALL immediately set: state RUN, both banks all zero, discard counter 0, pending 0, cfg_err 0, cfg_busy 0.
REQ-036 Reset mid-FLUSH SHALL abandon the flush with no further fir_valid pulses; the next edge after release operates in RUN.

Configuration
REQ-037 Macro FIR_CTRL_STATS_EN SHALL, when defined, add outputs stat_samples (16 bit, counts accepted s_valid&&s_ready) and stat_commits (16 bit, counts SWAP entries), both saturating at 0xFFFF and reset to 0.
REQ-038 Without FIR_CTRL_STATS_EN these ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-039 Reset, write taps 0..14 = 1, commit -> cfg_busy rises next cycle, fir_coeffs all 1 after SWAP, 15 zero fir_valid pulses with s_ready=0, then RUN.
REQ-040 After flush, stream s_data=100 continuously with FIR fed back -> first 15 fir_out_valid pulses after SWAP suppressed, thereafter m_valid=1 each sample.
REQ-041 Commit at 3rd FLUSH cycle with tap 0 rewritten to -2 -> second SWAP directly after flush, fir_coeffs[0]=-2, total 30 flush pulses, cfg_busy continuous.
REQ-042 Write addr 15 data 7 -> shadow unchanged, cfg_err=1 until rst.
REQ-043 Assert rst at 5th FLUSH cycle -> fir_valid=0 immediately, fir_coeffs all 0, s_ready=1 after release.
REQ-044 With FIR_CTRL_STATS_EN, 70000 accepted samples and 2 commits -> stat_samples=0xFFFF, stat_commits=2.
